// File: rtl/motor_setpoint_ramp.sv
// rtl/motor_setpoint_ramp.sv - throttle command to slew-limited PWM pulse width with arm/kill sequencing
module motor_setpoint_ramp #(
    parameter int PERIOD_CYC = 20000,
    parameter int MIN_PULSE  = 1000,
    parameter int MAX_PULSE  = 2000,
    parameter int STEP       = 10,
    parameter int UPDATE_DIV = 20000,
    parameter int ARM_HOLD   = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        arm_req,
    input  logic        kill,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_throttle,
    output logic [31:0] time_work,
    output logic [31:0] period,
    output logic        armed,
    output logic [1:0]  state,
    output logic        cmd_sat
);

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMING   = 2'd1,
        ST_ARMED    = 2'd2
    } state_e;

    localparam logic [31:0] PERIOD_W   = 32'(PERIOD_CYC);
    localparam logic [31:0] MIN_W      = 32'(MIN_PULSE);
    localparam logic [31:0] MAX_W      = 32'(MAX_PULSE);
    localparam logic [31:0] SPAN_W     = 32'(MAX_PULSE - MIN_PULSE);
    localparam logic [31:0] STEP_W     = 32'(STEP);
    localparam logic [31:0] DIV_LAST   = 32'(UPDATE_DIV - 1);
    localparam logic [31:0] HOLD_LAST  = 32'(ARM_HOLD - 1);

    state_e      state_q, state_d;
    logic [31:0] tick_cnt_q, tick_cnt_d;
    logic [31:0] time_work_q, time_work_d;
    logic [31:0] target_q, target_d;
    logic [31:0] arm_cnt_q, arm_cnt_d;
    logic        cmd_sat_q, cmd_sat_d;
    logic        armed_q, armed_d;

    logic        tick;
    logic        xfer;
    logic [31:0] throttle_ext;
    logic [31:0] ramp_next;

    assign cmd_ready    = reset & ~kill;
    assign xfer         = cmd_valid & cmd_ready;
    assign throttle_ext = {16'd0, cmd_throttle};
    assign tick         = (tick_cnt_q == DIV_LAST);
    assign tick_cnt_d   = tick ? 32'd0 : tick_cnt_q + 32'd1;

    // Ramp always moves toward the target registered before this edge.
    always_comb begin
        ramp_next = time_work_q;
        if (time_work_q < target_q) begin
            ramp_next = ((target_q - time_work_q) > STEP_W) ? time_work_q + STEP_W : target_q;
        end else if (time_work_q > target_q) begin
            ramp_next = ((time_work_q - target_q) > STEP_W) ? time_work_q - STEP_W : target_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        time_work_d = time_work_q;
        target_d    = target_q;
        arm_cnt_d   = arm_cnt_q;
        cmd_sat_d   = cmd_sat_q;

        if (xfer) begin
            if (throttle_ext <= SPAN_W) begin
                target_d  = MIN_W + throttle_ext;
                cmd_sat_d = 1'b0;
            end else begin
                target_d  = MAX_W;
                cmd_sat_d = 1'b1;
            end
        end

        if (kill) begin
            state_d     = ST_DISARMED;
            time_work_d = 32'd0;
            target_d    = MIN_W;
            arm_cnt_d   = 32'd0;
        end else begin
            case (state_q)
                ST_DISARMED: begin
                    time_work_d = 32'd0;
                    if (arm_req) begin
                        state_d     = ST_ARMING;
                        arm_cnt_d   = 32'd0;
                        time_work_d = MIN_W;
                    end
                end
                ST_ARMING: begin
                    time_work_d = MIN_W;
                    if (!arm_req) begin
                        state_d     = ST_DISARMED;
                        time_work_d = 32'd0;
                    end else if (tick) begin
                        arm_cnt_d = arm_cnt_q + 32'd1;
                        if (arm_cnt_q == HOLD_LAST) begin
                            state_d = ST_ARMED;
                        end
                    end
                end
                ST_ARMED: begin
                    if (!arm_req) begin
                        state_d     = ST_DISARMED;
                        time_work_d = 32'd0;
                        target_d    = MIN_W;
                    end else if (tick) begin
                        time_work_d = ramp_next;
                    end
                end
                default: begin
                    state_d     = ST_DISARMED;
                    time_work_d = 32'd0;
                end
            endcase
        end

        armed_d = (state_d == ST_ARMED);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_DISARMED;
            tick_cnt_q  <= 32'd0;
            time_work_q <= 32'd0;
            target_q    <= MIN_W;
            arm_cnt_q   <= 32'd0;
            cmd_sat_q   <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            time_work_q <= time_work_d;
            target_q    <= target_d;
            arm_cnt_q   <= arm_cnt_d;
            cmd_sat_q   <= cmd_sat_d;
            armed_q     <= armed_d;
        end
    end

    assign time_work = time_work_q;
    assign period    = PERIOD_W;
    assign armed     = armed_q;
    assign state     = state_q;
    assign cmd_sat   = cmd_sat_q;

endmodule

// File: tb/tb_motor_setpoint_ramp.sv
// tb/tb_motor_setpoint_ramp.sv - self-checking bench for motor_setpoint_ramp
module tb_motor_setpoint_ramp;

    localparam int PER  = 20000;
    localparam int MINP = 1000;
    localparam int MAXP = 2000;
    localparam int STP  = 10;
    localparam int DIV  = 10;
    localparam int HOLD = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        arm_req = 1'b0;
    logic        kill = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_throttle = 16'd0;
    logic [31:0] time_work;
    logic [31:0] period;
    logic        armed;
    logic [1:0]  state;
    logic        cmd_sat;

    int checks = 0;
    int failures = 0;

    motor_setpoint_ramp #(
        .PERIOD_CYC(PER), .MIN_PULSE(MINP), .MAX_PULSE(MAXP),
        .STEP(STP), .UPDATE_DIV(DIV), .ARM_HOLD(HOLD)
    ) dut (
        .clk(clk), .reset(reset), .arm_req(arm_req), .kill(kill),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_throttle(cmd_throttle),
        .time_work(time_work), .period(period), .armed(armed),
        .state(state), .cmd_sat(cmd_sat)
    );

    always #5 clk = ~clk;

    // Reference model: edges since reset give the tick phase; state in plain ints.
    int m_state, m_tw, m_target, m_arm, m_edge;
    bit m_sat;
    wire m_tick = ((m_edge % DIV) == DIV - 1);

    function automatic int toward(input int cur, input int tgt);
        int d = tgt - cur;
        if (d > STP) d = STP;
        if (d < -STP) d = -STP;
        return cur + d;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_state <= 0; m_tw <= 0; m_target <= MINP; m_arm <= 0; m_edge <= 0; m_sat <= 1'b0;
        end else begin
            m_edge <= m_edge + 1;
            if (kill) begin
                m_state <= 0; m_tw <= 0; m_target <= MINP; m_arm <= 0;
            end else begin
                if (cmd_valid) begin
                    m_target <= (int'(cmd_throttle) > MAXP - MINP) ? MAXP : MINP + int'(cmd_throttle);
                    m_sat    <= (int'(cmd_throttle) > MAXP - MINP);
                end
                if (m_state == 0) begin
                    if (arm_req) begin m_state <= 1; m_arm <= 0; m_tw <= MINP; end
                end else if (m_state == 1) begin
                    if (!arm_req) begin m_state <= 0; m_tw <= 0; end
                    else if (m_tick) begin
                        m_arm <= m_arm + 1;
                        if (m_arm + 1 == HOLD) m_state <= 2;
                    end
                end else begin
                    if (!arm_req) begin m_state <= 0; m_tw <= 0; m_target <= MINP; end
                    else if (m_tick) m_tw <= toward(m_tw, m_target);
                end
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("m_state", state, m_state);
        check("m_time_work", time_work, m_tw);
        check("m_armed", armed, m_state == 2);
        check("m_period", period, PER);
        check("m_cmd_sat", cmd_sat, m_sat);
        check("m_cmd_ready", cmd_ready, reset && !kill);
    end

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input int v);
        cmd_throttle = 16'(v);
        cmd_valid = 1'b1;
        edge1();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_tw_change(input string name, input int exp);
        logic [31:0] prev;
        int n;
        prev = time_work;
        n = 0;
        while (time_work == prev && n < 3 * DIV) begin
            @(negedge clk);
            n++;
        end
        check(name, time_work, exp);
    endtask

    task automatic wait_state(input string name, input int st, input int budget);
        int n;
        n = 0;
        while (int'(state) != st && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, state, st);
    endtask

    task automatic wait_tw(input string name, input int v, input int budget);
        int n;
        n = 0;
        while (int'(time_work) != v && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, time_work, v);
    endtask

    initial begin
        repeat (3) edge1();
        reset = 1'b1;
        repeat (5 * DIV) edge1();
        check("idle_state", state, 0);
        check("idle_tw", time_work, 0);
        check("idle_period", period, 20000);
        check("idle_ready", cmd_ready, 1);
        check("idle_armed", armed, 0);

        arm_req = 1'b1;
        edge1();
        check("arming_state", state, 1);
        check("arming_tw", time_work, 1000);
        wait_state("armed_reached", 2, 4 * DIV);
        check("armed_flag", armed, 1);
        check("armed_tw", time_work, 1000);

        send_cmd(25);
        wait_tw_change("ramp_1010", 1010);
        wait_tw_change("ramp_1020", 1020);
        wait_tw_change("ramp_1025", 1025);
        send_cmd(0);
        wait_tw_change("ramp_1015", 1015);
        wait_tw_change("ramp_1005", 1005);
        wait_tw_change("ramp_1000", 1000);

        send_cmd(1500);
        check("clamp_sat", cmd_sat, 1);
        repeat (105 * DIV) edge1();
        check("clamp_tw", time_work, 2000);
        send_cmd(100);
        check("unclamp_sat", cmd_sat, 0);

        wait_tw("reach_1500", 1500, 60 * DIV);
        kill = 1'b1;
        edge1();
        kill = 1'b0;
        check("kill_state", state, 0);
        check("kill_tw", time_work, 0);
        edge1();
        check("rearm_state", state, 1);
        check("rearm_tw", time_work, 1000);
        wait_state("rearmed", 2, 4 * DIV);
        check("rearmed_tw", time_work, 1000);

        send_cmd(800);
        wait_tw("reach_1800", 1800, 90 * DIV);
        send_cmd(5000);
        check("sat_before_reset", cmd_sat, 1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("areset_state", state, 0);
        check("areset_tw", time_work, 0);
        check("areset_armed", armed, 0);
        check("areset_sat", cmd_sat, 0);
        check("areset_period", period, 20000);
        check("areset_ready", cmd_ready, 0);
        edge1();
        reset = 1'b1;

        wait_state("post_reset_armed", 2, 5 * DIV);
        arm_req = 1'b0;
        edge1();
        check("disarm_state", state, 0);
        check("disarm_tw", time_work, 0);
        repeat (2 * DIV) edge1();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
